// File: rtl/sincos_pkg.sv
// Shared definitions for the sin/cos request arbiter: FSM state encoding and
// default widths/limits for the Box-Muller sin/cos sharing path.
package sincos_pkg;

  localparam int SINCOS_ADDR_W  = 33;
  localparam int SINCOS_DATA_W  = 16;
  localparam int SINCOS_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/sincos_req_arbiter_rr.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not served last. Purely combinational, one-hot output.
module rr_arbiter2 (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    unique case (req_valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/sincos_req_arbiter.sv
// Shares one sin/cos interpolation unit between two requesters: grant, restart,
// wait for done, return result. Optional WAIT watchdog: SINCOS_TIMEOUT_EN.
module sincos_req_arbiter
  import sincos_pkg::*;
#(
  parameter int ADDR_W  = SINCOS_ADDR_W,
  parameter int DATA_W  = SINCOS_DATA_W,
  parameter int TIMEOUT = SINCOS_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [2*ADDR_W-1:0] req_addr,
  output logic [1:0]          req_ready,
  output logic                su_reset,
  output logic                su_enable,
  output logic [ADDR_W-1:0]   su_address,
  input  logic                su_done,
  input  logic [DATA_W-1:0]   su_sin,
  input  logic [DATA_W-1:0]   su_cos,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_sin,
  output logic [DATA_W-1:0]   rsp_cos,
  output logic                rsp_err,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                id_q, id_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   sin_q, sin_d;
  logic [DATA_W-1:0]   cos_q, cos_d;
  logic [1:0]          grant;

`ifdef SINCOS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  rr_arbiter2 u_arb (
    .req_valid_i  (req_valid),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );

  // Next-state logic; su_done is only looked at in WAIT, so a level left high
  // from the previous operation cannot complete the restart in ISSUE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    id_d      = id_q;
    last_d    = last_q;
    sin_d     = sin_q;
    cos_d     = cos_q;
    req_ready = 2'b00;
`ifdef SINCOS_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!reset && (grant != 2'b00)) begin
          req_ready = grant;
          addr_d    = grant[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          id_d      = grant[1];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef SINCOS_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (su_done) begin
          sin_d   = su_sin;
          cos_d   = su_cos;
`ifdef SINCOS_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_RESP;
        end
`ifdef SINCOS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          sin_d   = '0;
          cos_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready[id_q]) begin
          last_d  = id_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      sin_q   <= '0;
      cos_q   <= '0;
`ifdef SINCOS_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      last_q  <= last_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
`ifdef SINCOS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign su_reset   = reset | (state_q == ST_ISSUE);
  assign su_enable  = (state_q == ST_WAIT);
  assign su_address = addr_q;
  assign rsp_valid  = (state_q == ST_RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_sin    = sin_q;
  assign rsp_cos    = cos_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef SINCOS_TIMEOUT_EN
  assign rsp_err    = err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sincos_req_arbiter.sv
// Self-checking bench for sincos_req_arbiter with a behavioural sin/cos unit
// and a round-robin reference model; timeout scenarios follow SINCOS_TIMEOUT_EN.
module tb_sincos_req_arbiter;

  localparam int AW = 33;
  localparam int DW = 16;
  localparam int NEVER = 1000000;

  logic          clk;
  logic          reset;
  logic [1:0]    req_valid;
  logic [2*AW-1:0] req_addr;
  logic [1:0]    req_ready;
  logic          su_reset;
  logic          su_enable;
  logic [AW-1:0] su_address;
  logic          su_done;
  logic [DW-1:0] su_sin;
  logic [DW-1:0] su_cos;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_sin;
  logic [DW-1:0] rsp_cos;
  logic          rsp_err;
  logic          busy;

  int checks = 0;
  int passed = 0;
  int lastModel = 1;

  // Behavioural sin/cos unit: done rises unitLat cycles into the enabled phase.
  int            waitCnt = 0;
  int            unitLat = NEVER;
  logic          stale = 1'b0;
  logic [DW-1:0] unitSin = '0;
  logic [DW-1:0] unitCos = '0;

  always @(posedge clk) begin
    if (su_reset) waitCnt <= 0;
    else if (su_enable) waitCnt <= waitCnt + 1;
  end

  assign su_done = stale | (su_enable && (waitCnt >= unitLat));
  assign su_sin  = su_enable ? unitSin : 16'hDEAD;
  assign su_cos  = su_enable ? unitCos : 16'hBEEF;

  sincos_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .su_reset   (su_reset),
      .su_enable  (su_enable),
      .su_address (su_address),
      .su_done    (su_done),
      .su_sin     (su_sin),
      .su_cos     (su_cos),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_sin    (rsp_sin),
      .rsp_cos    (rsp_cos),
      .rsp_err    (rsp_err),
      .busy       (busy)
    );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    stale     = 1'b0;
    repeat (2) nextCycle();
    reset     = 1'b0;
    lastModel = 1;
  endtask

  // Drives one complete operation starting in an IDLE cycle and reports what
  // was observed; the losing requester keeps requesting afterwards.
  task automatic runOp(
    input  logic [1:0]      valids,
    input  logic [2*AW-1:0] addrs,
    input  int              lat,
    input  logic [DW-1:0]   s,
    input  logic [DW-1:0]   c,
    input  int              readyDelay,
    input  logic            staleDone,
    output logic [1:0]      gGrant,
    output logic            gIssueRst,
    output logic [AW-1:0]   gAddr,
    output int              gLat,
    output logic [1:0]      gRspV,
    output logic [DW-1:0]   gSin,
    output logic [DW-1:0]   gCos,
    output logic            gErr,
    output logic            gStable,
    output logic            gBusyAfter
  );
    gStable   = 1'b1;
    req_valid = valids;
    req_addr  = addrs;
    unitLat   = lat;
    unitSin   = s;
    unitCos   = c;
    stale     = staleDone;
    rsp_ready = 2'b00;
    @(negedge clk);
    gGrant = req_ready;
    nextCycle();
    req_valid = valids & ~gGrant;
    @(negedge clk);
    gIssueRst = su_reset;
    gAddr     = su_address;
    gLat      = 1;
    while (rsp_valid === 2'b00 && gLat < 300) begin
      nextCycle();
      @(negedge clk);
      gLat++;
      if (su_enable === 1'b1 && su_address !== gAddr) gStable = 1'b0;
    end
    gRspV = rsp_valid;
    gSin  = rsp_sin;
    gCos  = rsp_cos;
    gErr  = rsp_err;
    for (int n = 0; n < readyDelay; n++) begin
      rsp_ready = ~gRspV;
      nextCycle();
      @(negedge clk);
      if (rsp_valid !== gRspV || rsp_sin !== gSin || rsp_cos !== gCos ||
          rsp_err !== gErr || req_ready !== 2'b00)
        gStable = 1'b0;
    end
    rsp_ready = gRspV;
    nextCycle();
    rsp_ready  = 2'b00;
    stale      = 1'b0;
    gBusyAfter = busy;
  endtask

  logic [1:0]    oGrant, oRspV;
  logic          oIssueRst, oErr, oStable, oBusyAfter;
  logic [AW-1:0] oAddr;
  logic [DW-1:0] oSin, oCos;
  int            oLat;

  task automatic test_reset();
    applyReset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (su_reset !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 2'b00 ||
        su_enable !== 1'b0 || busy !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_sin !== 16'h0 || rsp_cos !== 16'h0 || su_address !== '0)
      $display("[TB] FAIL reset_values: su_reset=%b req_ready=%b rsp_valid=%b su_enable=%b busy=%b err=%b sin=%h cos=%h addr=%h, expected 1 00 00 0 0 0 0000 0000 0",
               su_reset, req_ready, rsp_valid, su_enable, busy, rsp_err, rsp_sin, rsp_cos, su_address);
    else passed++;
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (su_reset !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL reset_release: su_reset=%b busy=%b, expected 0 0", su_reset, busy);
    else passed++;
    nextCycle();
  endtask

  task automatic test_single();
    runOp(2'b01, {33'h0, 33'h0_0001_0040}, 4, 16'h1234, 16'hABCD, 0, 1'b0,
          oGrant, oIssueRst, oAddr, oLat, oRspV, oSin, oCos, oErr, oStable, oBusyAfter);
    checks++;
    if (oGrant !== 2'b01) $display("[TB] FAIL single_grant: got %b expected 01", oGrant);
    else passed++;
    checks++;
    if (oIssueRst !== 1'b1 || oAddr !== 33'h0_0001_0040)
      $display("[TB] FAIL single_issue: su_reset=%b addr=%h expected 1 000010040", oIssueRst, oAddr);
    else passed++;
    checks++;
    if (oLat !== 7) $display("[TB] FAIL single_latency: rsp_valid at T+%0d expected T+7", oLat);
    else passed++;
    checks++;
    if (oRspV !== 2'b01 || oSin !== 16'h1234 || oCos !== 16'hABCD || oErr !== 1'b0)
      $display("[TB] FAIL single_data: valid=%b sin=%h cos=%h err=%b expected 01 1234 abcd 0",
               oRspV, oSin, oCos, oErr);
    else passed++;
    checks++;
    if (oBusyAfter !== 1'b0) $display("[TB] FAIL single_free: busy=%b expected 0", oBusyAfter);
    else passed++;
    lastModel = 0;
  endtask

  task automatic test_fairness();
    logic [DW-1:0] s, c;
    int lat;
    applyReset();
    for (int i = 0; i < 4; i++) begin
      s   = DW'($urandom);
      c   = DW'($urandom);
      lat = $urandom_range(0, 5);
      runOp(2'b11, {33'h1_0000_0AAA, 33'h0_5555_0001}, lat, s, c, 0, 1'b0,
            oGrant, oIssueRst, oAddr, oLat, oRspV, oSin, oCos, oErr, oStable, oBusyAfter);
      checks++;
      if (oGrant !== 2'(1 << (i % 2)) || oRspV !== oGrant)
        $display("[TB] FAIL fair_grant%0d: grant=%b rsp_valid=%b expected %b", i, oGrant, oRspV, 2'(1 << (i % 2)));
      else passed++;
      checks++;
      if (oAddr !== ((i % 2) ? 33'h1_0000_0AAA : 33'h0_5555_0001) || oSin !== s || oCos !== c || oLat !== 3 + lat)
        $display("[TB] FAIL fair_op%0d: addr=%h sin=%h cos=%h lat=%0d expected sin=%h cos=%h lat=%0d",
                 i, oAddr, oSin, oCos, oLat, s, c, 3 + lat);
      else passed++;
      lastModel = i % 2;
    end
  endtask

  task automatic test_back_pressure();
    runOp(2'b11, {33'h1_FFFF_0000, 33'h0_0000_FFFF}, 2, 16'h7001, 16'h8002, 10, 1'b0,
          oGrant, oIssueRst, oAddr, oLat, oRspV, oSin, oCos, oErr, oStable, oBusyAfter);
    checks++;
    if (oGrant !== 2'b01 || oRspV !== 2'b01)
      $display("[TB] FAIL bp_grant: grant=%b rsp_valid=%b expected 01 01", oGrant, oRspV);
    else passed++;
    checks++;
    if (oStable !== 1'b1 || oSin !== 16'h7001 || oCos !== 16'h8002)
      $display("[TB] FAIL bp_stable: stable=%b sin=%h cos=%h expected 1 7001 8002", oStable, oSin, oCos);
    else passed++;
    lastModel = 0;
    runOp(2'b10, {33'h1_FFFF_0000, 33'h0_0000_FFFF}, 1, 16'h0102, 16'h0304, 0, 1'b0,
          oGrant, oIssueRst, oAddr, oLat, oRspV, oSin, oCos, oErr, oStable, oBusyAfter);
    checks++;
    if (oGrant !== 2'b10 || oAddr !== 33'h1_FFFF_0000 || oRspV !== 2'b10 || oLat !== 4)
      $display("[TB] FAIL bp_pending: grant=%b addr=%h rsp_valid=%b lat=%0d expected 10 1ffff0000 10 4",
               oGrant, oAddr, oRspV, oLat);
    else passed++;
    lastModel = 1;
  endtask

  task automatic test_stale_done();
    runOp(2'b01, {33'h0, 33'h0_0BAD_F00D}, 0, 16'h4444, 16'h5555, 0, 1'b1,
          oGrant, oIssueRst, oAddr, oLat, oRspV, oSin, oCos, oErr, oStable, oBusyAfter);
    checks++;
    if (oLat !== 3 || oSin !== 16'h4444 || oCos !== 16'h5555 || oRspV !== 2'b01)
      $display("[TB] FAIL stale_done: lat=%0d sin=%h cos=%h valid=%b expected 3 4444 5555 01",
               oLat, oSin, oCos, oRspV);
    else passed++;
    lastModel = 0;
  endtask

`ifdef SINCOS_TIMEOUT_EN
  task automatic test_timeout();
    runOp(2'b01, {33'h0, 33'h0_0000_0123}, NEVER, 16'h1111, 16'h2222, 0, 1'b0,
          oGrant, oIssueRst, oAddr, oLat, oRspV, oSin, oCos, oErr, oStable, oBusyAfter);
    checks++;
    if (oLat !== 10 || oRspV !== 2'b01 || oSin !== 16'h0 || oCos !== 16'h0 || oErr !== 1'b1)
      $display("[TB] FAIL timeout_fire: lat=%0d valid=%b sin=%h cos=%h err=%b expected 10 01 0000 0000 1",
               oLat, oRspV, oSin, oCos, oErr);
    else passed++;
    lastModel = 0;
    runOp(2'b01, {33'h0, 33'h0_0000_0124}, 7, 16'h3333, 16'h6666, 0, 1'b0,
          oGrant, oIssueRst, oAddr, oLat, oRspV, oSin, oCos, oErr, oStable, oBusyAfter);
    checks++;
    if (oLat !== 10 || oSin !== 16'h3333 || oCos !== 16'h6666 || oErr !== 1'b0)
      $display("[TB] FAIL timeout_done_wins: lat=%0d sin=%h cos=%h err=%b expected 10 3333 6666 0",
               oLat, oSin, oCos, oErr);
    else passed++;
    lastModel = 0;
  endtask
`endif

  task automatic test_reset_mid_wait(input int hold);
    logic holdOk;
    logic noRsp;
    holdOk    = 1'b1;
    noRsp     = 1'b1;
    req_valid = 2'b10;
    req_addr  = {33'h1_2345_6789, 33'h0};
    unitLat   = NEVER;
    nextCycle();
    req_valid = 2'b00;
    repeat (hold + 1) begin
      nextCycle();
      @(negedge clk);
      if (!(busy === 1'b1 && rsp_valid === 2'b00 && su_enable === 1'b1)) holdOk = 1'b0;
    end
    checks++;
    if (holdOk !== 1'b1)
      $display("[TB] FAIL wait_hold: stayed_in_wait=%b over %0d cycles expected 1", holdOk, hold);
    else passed++;
    nextCycle();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (su_reset !== 1'b1) $display("[TB] FAIL midreset_sureset: got %b expected 1", su_reset);
    else passed++;
    nextCycle();
    reset     = 1'b0;
    lastModel = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || su_enable !== 1'b0 || su_reset !== 1'b0 || su_address !== '0 ||
        rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_sin !== 16'h0 || rsp_cos !== 16'h0)
      $display("[TB] FAIL midreset_values: busy=%b en=%b sr=%b addr=%h valid=%b err=%b sin=%h cos=%h expected all zero",
               busy, su_enable, su_reset, su_address, rsp_valid, rsp_err, rsp_sin, rsp_cos);
    else passed++;
    repeat (5) begin
      nextCycle();
      @(negedge clk);
      if (rsp_valid !== 2'b00 || busy !== 1'b0) noRsp = 1'b0;
    end
    checks++;
    if (noRsp !== 1'b1) $display("[TB] FAIL midreset_no_rsp: quiet=%b expected 1", noRsp);
    else passed++;
    nextCycle();
    runOp(2'b11, {33'h1_0000_0002, 33'h0_0000_0001}, 1, 16'h0F0F, 16'hF0F0, 0, 1'b0,
          oGrant, oIssueRst, oAddr, oLat, oRspV, oSin, oCos, oErr, oStable, oBusyAfter);
    checks++;
    if (oGrant !== 2'b01 || oRspV !== 2'b01 || oSin !== 16'h0F0F)
      $display("[TB] FAIL midreset_regrant: grant=%b valid=%b sin=%h expected 01 01 0f0f", oGrant, oRspV, oSin);
    else passed++;
    lastModel = 0;
  endtask

  task automatic test_random();
    logic [1:0]      valids;
    logic [2*AW-1:0] addrs;
    logic [DW-1:0]   s, c;
    logic [AW-1:0]   expAddr;
    int              lat, delay, expId;
    for (int i = 0; i < 20; i++) begin
      valids = 2'($urandom_range(1, 3));
      addrs  = {2'($urandom_range(0, 3)), 32'($urandom), 32'($urandom)};
      s      = DW'($urandom);
      c      = DW'($urandom);
      lat    = $urandom_range(0, 6);
      delay  = $urandom_range(0, 3);
      expId  = (valids == 2'b11) ? 1 - lastModel : ((valids == 2'b10) ? 1 : 0);
      expAddr = addrs[expId*AW +: AW];
      runOp(valids, addrs, lat, s, c, delay, 1'b0,
            oGrant, oIssueRst, oAddr, oLat, oRspV, oSin, oCos, oErr, oStable, oBusyAfter);
      checks++;
      if (oGrant !== 2'(1 << expId) || oRspV !== 2'(1 << expId) || oAddr !== expAddr)
        $display("[TB] FAIL rand%0d_grant: grant=%b valid=%b addr=%h expected id %0d addr %h",
                 i, oGrant, oRspV, oAddr, expId, expAddr);
      else passed++;
      checks++;
      if (oLat !== 3 + lat || oSin !== s || oCos !== c || oErr !== 1'b0 ||
          oStable !== 1'b1 || oBusyAfter !== 1'b0)
        $display("[TB] FAIL rand%0d_rsp: lat=%0d sin=%h cos=%h err=%b stable=%b busy=%b expected lat=%0d sin=%h cos=%h 0 1 0",
                 i, oLat, oSin, oCos, oErr, oStable, oBusyAfter, 3 + lat, s, c);
      else passed++;
      lastModel = expId;
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_addr  = '0;
    rsp_ready = 2'b00;
    test_reset();
    test_single();
    test_fairness();
    test_back_pressure();
    test_stale_done();
`ifdef SINCOS_TIMEOUT_EN
    test_timeout();
    test_reset_mid_wait(3);
`else
    test_reset_mid_wait(200);
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
